// File: rtl/sync_cal_controller.sv
// sync_cal_controller: loads a target period, settles, then scores adjuster windows to declare lock or timeout.
// Define SYNC_CAL_RELOCK_EN to let LOCKED fall back to MEASURE after LOSS_CNT consecutive bad windows.
module sync_cal_controller #(
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_CNT   = 4,
  parameter int LOSS_CNT   = 2,
  parameter int TIMEOUT    = 64,
  parameter int TOL        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] target,
  input  logic       meas_valid,
  input  logic [8:0] duration,
  input  logic       increment,
  input  logic       decrement,
  output logic [7:0] set_period,
  output logic       ld,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [9:0] last_err,
  output logic [7:0] win_cnt
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, MEASURE, LOCKED, FAIL} state_t;
  state_t        state, state_n;
  logic [SW-1:0] settle, settle_n;
  logic [3:0]    good, good_n, bad, bad_n;
  logic [7:0]    set_period_n, win_cnt_n, win_inc;
  logic [9:0]    last_err_n, err, err_abs;
  logic          in_band, lock_hit, loss_hit, restart, settle_done;
  assign err         = {1'b0, duration} - {2'b0, set_period};
  assign err_abs     = err[9] ? -err : err;
  assign in_band     = err_abs <= 10'(TOL) && !(increment && decrement);
  assign win_inc     = win_cnt == 8'hff ? win_cnt : win_cnt + 8'd1;
  assign lock_hit    = in_band && good + 4'd1 == 4'(LOCK_CNT);
  assign loss_hit    = !in_band && bad + 4'd1 == 4'(LOSS_CNT);
  assign restart     = start && (state == IDLE || state == LOCKED || state == FAIL);
  assign settle_done = settle == SW'(SETTLE_CYC - 1);
  always_comb begin
    state_n      = state;
    settle_n     = settle;
    good_n       = good;
    bad_n        = bad;
    set_period_n = set_period;
    win_cnt_n    = win_cnt;
    last_err_n   = last_err;
    if (abort) begin
      state_n   = IDLE;
      settle_n  = '0;
      good_n    = '0;
      bad_n     = '0;
      win_cnt_n = '0;
    end else if (restart) begin
      state_n      = LOAD;
      set_period_n = target;
      settle_n     = '0;
      good_n       = '0;
      bad_n        = '0;
      win_cnt_n    = '0;
    end else begin
      case (state)
        LOAD: state_n = SETTLE;
        SETTLE: begin
          settle_n = settle_done ? '0 : settle + SW'(1);
          state_n  = settle_done ? MEASURE : SETTLE;
        end
        MEASURE: if (meas_valid) begin
          last_err_n = err;
          win_cnt_n  = win_inc;
          good_n     = in_band ? good + 4'd1 : '0;
          state_n    = lock_hit ? LOCKED : win_inc == 8'(TIMEOUT) ? FAIL : MEASURE;
        end
        // bad tracks consecutive out-of-band windows while locked
        LOCKED: if (meas_valid) begin
          last_err_n = err;
          bad_n      = in_band || loss_hit ? '0 : bad + 4'd1;
`ifdef SYNC_CAL_RELOCK_EN
          if (loss_hit) begin
            state_n   = MEASURE;
            good_n    = '0;
            win_cnt_n = '0;
          end
`else
`endif
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      settle     <= '0;
      good       <= '0;
      bad        <= '0;
      set_period <= '0;
      win_cnt    <= '0;
      last_err   <= '0;
      ld         <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      settle     <= settle_n;
      good       <= good_n;
      bad        <= bad_n;
      set_period <= set_period_n;
      win_cnt    <= win_cnt_n;
      last_err   <= last_err_n;
      ld         <= state_n == LOAD;
      busy       <= state_n == LOAD || state_n == SETTLE || state_n == MEASURE;
      locked     <= state_n == LOCKED;
      fail       <= state_n == FAIL;
    end
  end
endmodule

// File: tb/tb_sync_cal_controller.sv
// tb_sync_cal_controller: directed and random stimulus checked every cycle against a window-history model.
module tb_sync_cal_controller;
  localparam int S = 16, LOCK = 4, LOSS = 2, TMO = 64, TOL = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_LOCK = 2, M_FAIL = 3;
  logic clk = 0, rst = 0, start = 0, abort = 0, meas_valid = 0, increment = 0, decrement = 0;
  logic [7:0] target = 0;
  logic [8:0] duration = 0;
  logic [7:0] set_period, win_cnt;
  logic       ld, busy, locked, fail;
  logic [9:0] last_err;
  int errors = 0, checks = 0;
  int mode = M_IDLE, e = 0, t0 = -100, mfrom = 0, m_sp = 0, m_le = 0, err;
  bit ib;
  bit win[$], lw[$];

  sync_cal_controller dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
    .meas_valid(meas_valid), .duration(duration), .increment(increment), .decrement(decrement),
    .set_period(set_period), .ld(ld), .busy(busy), .locked(locked), .fail(fail),
    .last_err(last_err), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit tail(bit sel, int n, bit v);
    int sz = sel ? lw.size() : win.size();
    if (sz < n) return 0;
    for (int i = sz - n; i < sz; i++) if ((sel ? lw[i] : win[i]) != v) return 0;
    return 1;
  endfunction

  // model keeps the history of scored windows; streaks are read off the queue tails
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode = M_IDLE; m_sp = 0; m_le = 0; t0 = -100; mfrom = 0;
      win.delete(); lw.delete();
    end else begin
      e++;
      if (abort) begin
        mode = M_IDLE; win.delete(); lw.delete();
      end else if (start && mode != M_RUN) begin
        mode = M_RUN; t0 = e; mfrom = e + 2 + S; m_sp = int'(target);
        win.delete(); lw.delete();
      end else if (meas_valid && (mode == M_LOCK || (mode == M_RUN && e >= mfrom))) begin
        err = int'(duration) - m_sp;
        ib = (err < 0 ? -err : err) <= TOL && !(increment && decrement);
        m_le = err;
        if (mode == M_RUN) begin
          win.push_back(ib);
          if (tail(0, LOCK, 1)) mode = M_LOCK;
          else if (win.size() == TMO) mode = M_FAIL;
        end else begin
          lw.push_back(ib);
`ifdef SYNC_CAL_RELOCK_EN
          if (tail(1, LOSS, 0)) begin
            mode = M_RUN; t0 = -100; mfrom = e + 1; win.delete(); lw.delete();
          end
`endif
        end
      end
    end
    #1;
    chk("cmp ld", ld, int'(mode == M_RUN && e == t0));
    chk("cmp busy", busy, int'(mode == M_RUN));
    chk("cmp locked", locked, int'(mode == M_LOCK));
    chk("cmp fail", fail, int'(mode == M_FAIL));
    chk("cmp set_period", set_period, m_sp);
    chk("cmp last_err", last_err, m_le & 'h3ff);
    chk("cmp win_cnt", win_cnt, win.size() > 255 ? 255 : win.size());
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(logic [7:0] t);
    start = 1; target = t; tick(); start = 0; tick(S + 1);
  endtask

  task automatic wnd(int d, bit inc = 0, bit dec = 0);
    meas_valid = 1; duration = 9'(d); increment = inc; decrement = dec;
    tick();
    meas_valid = 0; increment = 0; decrement = 0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int d;
    tick(2);
    chk("reset busy", busy, 0);
    chk("reset set_period", set_period, 0);
    chk("reset win_cnt", win_cnt, 0);
    rst = 1;
    tick();
    // lock, with meas_valid held through LOAD and all of SETTLE
    start = 1; target = 125; tick(); start = 0;
    chk("lock ld pulse", ld, 1);
    meas_valid = 1; duration = 125;
    tick(S + 1);
    meas_valid = 0;
    chk("settle win_cnt", win_cnt, 0);
    chk("settle ld low", ld, 0);
    wnd(125); wnd(126); wnd(124);
    chk("lock early", locked, 0);
    wnd(127);
    chk("lock locked", locked, 1);
    chk("lock last_err", last_err, 2);
    chk("lock win_cnt", win_cnt, 4);
    chk("lock busy", busy, 0);
    // timeout
    go(125);
    repeat (TMO - 1) wnd(130);
    chk("timeout early", fail, 0);
    wnd(130);
    chk("timeout fail", fail, 1);
    chk("timeout locked", locked, 0);
    chk("timeout last_err", last_err, 5);
    chk("timeout win_cnt", win_cnt, 64);
    // streak reset
    go(125);
    repeat (3) wnd(125);
    wnd(130);
    repeat (3) wnd(125);
    chk("streak 7th", locked, 0);
    wnd(125);
    chk("streak 8th", locked, 1);
    chk("streak win_cnt", win_cnt, 8);
    // loss of lock
    wnd(130);
    chk("loss first", locked, 1);
    wnd(130);
`ifdef SYNC_CAL_RELOCK_EN
    chk("relock drop", locked, 0);
    chk("relock busy", busy, 1);
    chk("relock win_cnt", win_cnt, 0);
    repeat (4) wnd(125);
    chk("relock again", locked, 1);
`else
    chk("nolock stays", locked, 1);
    chk("nolock busy", busy, 0);
    chk("nolock last_err", last_err, 5);
`endif
    // increment and decrement together is out-of-band
    go(125);
    repeat (3) wnd(125);
    wnd(125, 1, 1);
    chk("incdec locked", locked, 0);
    chk("incdec win_cnt", win_cnt, 4);
    repeat (3) wnd(125);
    chk("incdec 7th", locked, 0);
    wnd(125);
    chk("incdec 8th", locked, 1);
    // abort mid-MEASURE
    go(125);
    wnd(125);
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    chk("abort busy", busy, 0);
    chk("abort ld", ld, 0);
    chk("abort set_period", set_period, 125);
    chk("abort win_cnt", win_cnt, 0);
    // asynchronous reset mid-SETTLE
    start = 1; target = 77; tick(); start = 0;
    tick(3);
    #2 rst = 0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst set_period", set_period, 0);
    chk("arst ld", ld, 0);
    chk("arst locked", locked, 0);
    chk("arst fail", fail, 0);
    chk("arst last_err", last_err, 0);
    chk("arst win_cnt", win_cnt, 0);
    tick(); rst = 1; tick();
    // random traffic
    repeat (3000) begin
      start = $urandom_range(0, 39) == 0;
      abort = $urandom_range(0, 299) == 0;
      target = 8'($urandom_range(4, 250));
      meas_valid = $urandom_range(0, 2) == 0;
      d = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 511)) : m_sp + int'($urandom_range(0, 6)) - 3;
      duration = 9'(d < 0 ? 0 : d);
      increment = $urandom_range(0, 9) == 0;
      decrement = $urandom_range(0, 9) == 0;
      tick();
    end
    start = 0; abort = 0; meas_valid = 0; increment = 0; decrement = 0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
